int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_SRC, default 6: number of interrupt sources; legal range 1..8.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-004 Src  input  N_SRC  interrupt requests from devices (e.g. counter INT_REQ lines); bit 0 has the highest priority.
REQ-005 Addr  input  2  register word select, driven from bus address bits [3:2].
REQ-006 Write_Enabled  input  1  register write strobe from the bridge.
REQ-007 Data_In  input  32  write data.
REQ-008 Data_Out  output  32  read data; combinational on Addr.
REQ-009 HW_INT  output  N_SRC  registered one-hot request to the CPU for the in-service source.
REQ-010 Irq  output  1  registered OR of HW_INT.

Function
REQ-011 The register map SHALL be as follows:
- Addr 0: MASK, read/write, bits [N_SRC-1:0].
- Addr 1: PENDING, read; a write clears each bit where Data_In is 1 (write-1-to-clear).
- Addr 2: STATUS, read-only; bit 31 = in service, bits [2:0] = VEC.
- Addr 3: ACK, write-only; reads return 0.
REQ-012 Unused bits SHALL read 0, and writes to them SHALL be ignored.
REQ-013 A source event SHALL set its PENDING bit one cycle after the event; the bit stays set until cleared.
REQ-014 The FSM SHALL have two states, IDLE and SERVICE.
REQ-015 In IDLE, when (PENDING & MASK) is nonzero, the FSM SHALL latch the lowest set index into VEC and enter SERVICE; HW_INT = onehot(VEC) and Irq = 1 from the next cycle.
REQ-016 In SERVICE, a write to ACK SHALL clear PENDING[VEC] and return the FSM to IDLE; HW_INT and Irq fall in the following cycle.
REQ-017 In SERVICE, if MASK[VEC] is cleared or PENDING[VEC] is cleared through Addr 1, the FSM SHALL return to IDLE without an ACK (withdraw); PENDING[VEC] is left as written.
REQ-018 VEC SHALL NOT change while in SERVICE, even if a higher-priority source becomes pending; preemption happens only via IDLE.
REQ-019 A write to ACK in IDLE SHALL have no effect.
REQ-020 When a source event and a clear of the same PENDING bit (W1C or ACK) occur in the same cycle, the set SHALL win.
REQ-021 Re-entry from IDLE SHALL take at least one IDLE cycle, so Irq shows a 1-cycle low gap between services.
REQ-022 Data_Out SHALL reflect register state before the current cycle's write.

Reset
REQ-023 Asserting reset low SHALL asynchronously force: MASK = 0, PENDING = 0, VEC = 0, state = IDLE, HW_INT = 0, Irq = 0, edge-history flops = 0.
REQ-024 Reset asserted mid-service SHALL drop Irq immediately, with no pending bits retained.
REQ-025 Normal operation SHALL resume on the first rising clk edge after reset deasserts.

Configuration
REQ-026 Macro INT_CTRL_EDGE_DETECT_EN SHALL select the source-event mode.
- Defined: a source event is a 0->1 transition of Src[i], detected against a registered copy of Src. A held-high Src sets PENDING once.
- Undefined: a source event is Src[i] == 1 on a clock edge (level mode). W1C or ACK of a still-high source is re-set next cycle.

Verification
REQ-027 Reset, then MASK=0x3, pulse Src[1] for 1 cycle -> PENDING=0x2 next cycle; Irq=1, HW_INT=0x02, STATUS=0x80000001 one cycle later.
REQ-028 Src[0] and Src[1] rise in the same cycle with MASK=0x3 -> VEC=0. After ACK -> one Irq-low cycle, then VEC=1, HW_INT=0x02. After a second ACK -> PENDING=0.
REQ-029 In SERVICE with VEC=1, write MASK=0x1 -> next cycle IDLE, Irq=0, PENDING still 0x2.
REQ-030 ACK written in the same cycle as a new rising edge on Src[VEC] -> PENDING[VEC] stays 1 and service re-enters after one IDLE cycle.
REQ-031 With INT_CTRL_EDGE_DETECT_EN defined, hold Src[2]=1 for 10 cycles with MASK=0x4, then ACK -> PENDING=0 and Irq stays 0. Without the macro, the same stimulus -> PENDING[2] re-sets and Irq re-asserts.
REQ-032 Drive reset low while Irq=1 and MASK=0x3F -> Irq, HW_INT, MASK and PENDING read 0 before the next clk edge.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: N_SRC sources, MASK/PENDING/STATUS/ACK register map,
// two-state IDLE/SERVICE FSM driving a registered one-hot HW_INT and Irq.
// Optional build macro INT_CTRL_EDGE_DETECT_EN: when defined, a source event is
// a 0->1 transition of Src; when undefined, a source event is Src high (level).
module int_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] Src,
  input  logic [1:0]       Addr,
  input  logic             Write_Enabled,
  input  logic [31:0]      Data_In,
  output logic [31:0]      Data_Out,
  output logic [N_SRC-1:0] HW_INT,
  output logic             Irq
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] src_event;
  logic [N_SRC-1:0] clr_bits;
  logic [N_SRC-1:0] ready;
  logic [N_SRC-1:0] vec_oh;
  logic [N_SRC-1:0] hw_int_d;
  logic             wr_mask, wr_w1c, wr_ack;
  logic             withdraw;
  logic             unused_data;

  // One-hot decode of a 3-bit vector index onto the source lanes.
  function automatic logic [N_SRC-1:0] onehot(input logic [2:0] v);
    logic [N_SRC-1:0] oh;
    for (int i = 0; i < N_SRC; i++) oh[i] = (v == i[2:0]);
    return oh;
  endfunction

  // Index of the lowest set bit (bit 0 is highest priority).
  function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] r);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (r[i]) idx = i[2:0];
    end
    return idx;
  endfunction

`ifdef INT_CTRL_EDGE_DETECT_EN
  logic [N_SRC-1:0] src_prev_q;

  // Registered copy of Src so a held-high source only produces one event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) src_prev_q <= '0;
    else        src_prev_q <= Src;
  end

  assign src_event = Src & ~src_prev_q;
`else
  assign src_event = Src;
`endif

  // Upper write-data bits have no destination; fold them away explicitly.
  assign unused_data = ^Data_In;

  assign wr_mask = Write_Enabled && (Addr == 2'd0);
  assign wr_w1c  = Write_Enabled && (Addr == 2'd1);
  // ACK outside SERVICE is ignored entirely.
  assign wr_ack  = Write_Enabled && (Addr == 2'd3) && (state_q == SERVICE);
  assign vec_oh  = onehot(vec_q);
  assign ready   = pend_q & mask_q;

  // Next register values: set beats clear when both hit the same PENDING bit.
  always_comb begin
    mask_d = mask_q;
    if (wr_mask) mask_d = Data_In[N_SRC-1:0];
    clr_bits = (wr_w1c ? Data_In[N_SRC-1:0] : '0) | (wr_ack ? vec_oh : '0);
    pend_d   = (pend_q & ~clr_bits) | src_event;
    // Service is withdrawn when its mask bit drops or its pending bit is
    // explicitly cleared through the PENDING register.
    withdraw = (|(vec_oh & ~mask_d)) ||
               (wr_w1c && (|(vec_oh & Data_In[N_SRC-1:0])));
  end

  // FSM next state; VEC only changes on IDLE->SERVICE so no preemption in service.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (|ready) begin
          vec_d   = lowest_idx(ready);
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (wr_ack || withdraw) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    hw_int_d = (state_d == SERVICE) ? onehot(vec_d) : '0;
  end

  // State, registers and registered CPU request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      HW_INT  <= '0;
      Irq     <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      HW_INT  <= hw_int_d;
      Irq     <= |hw_int_d;
    end
  end

  // Read mux reflects register state before this cycle's write.
  always_comb begin
    Data_Out = '0;
    case (Addr)
      2'd0:    Data_Out = {{(32 - N_SRC){1'b0}}, mask_q};
      2'd1:    Data_Out = {{(32 - N_SRC){1'b0}}, pend_q};
      2'd2:    Data_Out = {(state_q == SERVICE), 28'd0, vec_q};
      default: Data_Out = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_int_ctrl;
  localparam int N    = 6;
  localparam int FULL = (1 << N) - 1;

  logic          clk;
  logic          reset;
  logic [N-1:0]  Src;
  logic [1:0]    Addr;
  logic          Write_Enabled;
  logic [31:0]   Data_In;
  logic [31:0]   Data_Out;
  logic [N-1:0]  HW_INT;
  logic          Irq;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mask, m_pend, m_vec, m_prev;
  bit m_busy;

  int_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .reset(reset), .Src(Src), .Addr(Addr),
    .Write_Enabled(Write_Enabled), .Data_In(Data_In),
    .Data_Out(Data_Out), .HW_INT(HW_INT), .Irq(Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_read(input int a);
    case (a)
      0:       return m_mask;
      1:       return m_pend;
      2:       return (int'(m_busy) << 31) | m_vec;
      default: return 0;
    endcase
  endfunction

  // Reference behaviour for one clock edge given the inputs held during the cycle.
  task automatic model_step(input int src, input int a, input bit we, input int din);
    int  ev, clr, nmask, rdy;
    bit  ack;
`ifdef INT_CTRL_EDGE_DETECT_EN
    ev = src & ~m_prev;
`else
    ev = src;
`endif
    m_prev = src;
    nmask  = m_mask;
    clr    = 0;
    ack    = we && (a == 3) && m_busy;
    if (we && a == 0) nmask = din & FULL;
    if (we && a == 1) clr = din & FULL;
    if (ack) clr |= (1 << m_vec);
    rdy = m_pend & m_mask;
    if (m_busy) begin
      if (ack || (((nmask >> m_vec) & 1) == 0) || (we && a == 1 && (((din >> m_vec) & 1) == 1)))
        m_busy = 1'b0;
    end else if (rdy != 0) begin
      for (int i = N - 1; i >= 0; i--) if (((rdy >> i) & 1) == 1) m_vec = i;
      m_busy = 1'b1;
    end
    m_pend = ((m_pend & ~clr) | ev) & FULL;
    m_mask = nmask;
  endtask

  function automatic logic [N-1:0] m_hw();
    return m_busy ? N'(1 << m_vec) : '0;
  endfunction

  // Apply inputs for one cycle; Data_Out sampled at the falling edge.
  task automatic drive(input logic [N-1:0] s, input logic [1:0] a, input logic we,
                       input logic [31:0] d, output logic [31:0] dout_pre);
    Src = s; Addr = a; Write_Enabled = we; Data_In = d;
    @(negedge clk);
    dout_pre = Data_Out;
    @(posedge clk);
    #1;
    model_step(int'(s), int'(a), we, int'(d));
  endtask

  task automatic do_reset();
    reset = 1'b0; Src = '0; Addr = '0; Write_Enabled = 1'b0; Data_In = '0;
    m_mask = 0; m_pend = 0; m_vec = 0; m_prev = 0; m_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_step(0, 0, 1'b0, 0);
  endtask

  typedef struct {
    logic [N-1:0] src;
    logic [1:0]   addr;
    logic         we;
    logic [31:0]  din;
    logic [31:0]  exp_dout;
    logic         exp_irq;
    logic [N-1:0] exp_hw;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] d;
    logic [N-1:0] rs;
    logic [1:0]   ra;
    logic         rw;
    logic [31:0]  rd;
    int           exp_d;

    // Basic service flow: MASK=3, single pulse on Src[1], then ACK.
    tbl[0] = '{src: 6'h00, addr: 2'd0, we: 1'b1, din: 32'h3,  exp_dout: 32'h0,        exp_irq: 1'b0, exp_hw: 6'h00};
    tbl[1] = '{src: 6'h02, addr: 2'd1, we: 1'b0, din: 32'h0,  exp_dout: 32'h0,        exp_irq: 1'b0, exp_hw: 6'h00};
    tbl[2] = '{src: 6'h00, addr: 2'd1, we: 1'b0, din: 32'h0,  exp_dout: 32'h2,        exp_irq: 1'b1, exp_hw: 6'h02};
    tbl[3] = '{src: 6'h00, addr: 2'd2, we: 1'b0, din: 32'h0,  exp_dout: 32'h80000001, exp_irq: 1'b1, exp_hw: 6'h02};
    tbl[4] = '{src: 6'h00, addr: 2'd3, we: 1'b1, din: 32'h0,  exp_dout: 32'h0,        exp_irq: 1'b0, exp_hw: 6'h00};
    tbl[5] = '{src: 6'h00, addr: 2'd1, we: 1'b0, din: 32'h0,  exp_dout: 32'h0,        exp_irq: 1'b0, exp_hw: 6'h00};
    tbl[6] = '{src: 6'h00, addr: 2'd0, we: 1'b0, din: 32'h0,  exp_dout: 32'h3,        exp_irq: 1'b0, exp_hw: 6'h00};

    do_reset();
    chk("reset_irq", 32'(Irq), 32'h0);
    chk("reset_hw", 32'(HW_INT), 32'h0);
    Addr = 2'd2; #1;
    chk("reset_status", Data_Out, 32'h0);

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].src, tbl[i].addr, tbl[i].we, tbl[i].din, d);
      chk($sformatf("tbl%0d_dout", i), d, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_irq", i), 32'(Irq), 32'(tbl[i].exp_irq));
      chk($sformatf("tbl%0d_hw", i), 32'(HW_INT), 32'(tbl[i].exp_hw));
    end

    // Simultaneous Src[0]/Src[1]: priority, one-cycle gap, second service.
    do_reset();
    drive(6'h00, 2'd0, 1'b1, 32'h3, d);
    drive(6'h03, 2'd1, 1'b0, 32'h0, d);
    drive(6'h00, 2'd1, 1'b0, 32'h0, d);
    chk("prio_pend", d, 32'h3);
    chk("prio_hw0", 32'(HW_INT), 32'h1);
    drive(6'h00, 2'd2, 1'b0, 32'h0, d);
    chk("prio_status0", d, 32'h80000000);
    drive(6'h00, 2'd3, 1'b1, 32'h0, d);
    chk("prio_gap_irq", 32'(Irq), 32'h0);
    drive(6'h00, 2'd2, 1'b0, 32'h0, d);
    chk("prio_gap_status", d[31], 32'h0);
    chk("prio_hw1", 32'(HW_INT), 32'h2);
    drive(6'h00, 2'd2, 1'b0, 32'h0, d);
    chk("prio_status1", d, 32'h80000001);
    drive(6'h00, 2'd3, 1'b1, 32'h0, d);
    drive(6'h00, 2'd1, 1'b0, 32'h0, d);
    chk("prio_pend_final", d, 32'h0);
    chk("prio_irq_final", 32'(Irq), 32'h0);

    // Withdraw by masking the in-service source.
    do_reset();
    drive(6'h00, 2'd0, 1'b1, 32'h3, d);
    drive(6'h02, 2'd1, 1'b0, 32'h0, d);
    drive(6'h00, 2'd1, 1'b0, 32'h0, d);
    chk("wd_hw", 32'(HW_INT), 32'h2);
    drive(6'h00, 2'd0, 1'b1, 32'h1, d);
    chk("wd_irq", 32'(Irq), 32'h0);
    drive(6'h00, 2'd1, 1'b0, 32'h0, d);
    chk("wd_pend", d, 32'h2);
    chk("wd_irq_stay", 32'(Irq), 32'h0);

    // ACK coinciding with a new Src[VEC] rise: set wins, re-entry after a gap.
    do_reset();
    drive(6'h00, 2'd0, 1'b1, 32'h3, d);
    drive(6'h02, 2'd1, 1'b0, 32'h0, d);
    drive(6'h00, 2'd1, 1'b0, 32'h0, d);
    chk("ackset_hw", 32'(HW_INT), 32'h2);
    drive(6'h02, 2'd3, 1'b1, 32'h0, d);
    chk("ackset_irq_gap", 32'(Irq), 32'h0);
    drive(6'h00, 2'd1, 1'b0, 32'h0, d);
    chk("ackset_pend", d, 32'h2);
    chk("ackset_reenter", 32'(HW_INT), 32'h2);

    // Held-high Src[2] for 10 cycles, then ACK while still high.
    do_reset();
    drive(6'h00, 2'd0, 1'b1, 32'h4, d);
    for (int i = 0; i < 10; i++) drive(6'h04, 2'd1, 1'b0, 32'h0, d);
    chk("hold_hw", 32'(HW_INT), 32'h4);
    drive(6'h04, 2'd3, 1'b1, 32'h0, d);
    chk("hold_ack_irq", 32'(Irq), 32'h0);
    drive(6'h04, 2'd1, 1'b0, 32'h0, d);
`ifdef INT_CTRL_EDGE_DETECT_EN
    chk("hold_pend", d, 32'h0);
    chk("hold_irq", 32'(Irq), 32'h0);
`else
    chk("hold_pend", d, 32'h4);
    chk("hold_irq", 32'(Irq), 32'h1);
`endif
    drive(6'h00, 2'd0, 1'b0, 32'h0, d);

    // Asynchronous reset in the middle of a service.
    do_reset();
    drive(6'h00, 2'd0, 1'b1, 32'h3F, d);
    drive(6'h01, 2'd1, 1'b0, 32'h0, d);
    drive(6'h00, 2'd1, 1'b0, 32'h0, d);
    chk("arst_pre_irq", 32'(Irq), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_irq", 32'(Irq), 32'h0);
    chk("arst_hw", 32'(HW_INT), 32'h0);
    Addr = 2'd0; #1;
    chk("arst_mask", Data_Out, 32'h0);
    Addr = 2'd1; #1;
    chk("arst_pend", Data_Out, 32'h0);
    do_reset();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      rs = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      ra = 2'($urandom_range(0, 3));
      rw = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, FULL));
      exp_d = m_read(int'(ra));
      drive(rs, ra, rw, rd, d);
      chk($sformatf("rnd%0d_dout", i), d, 32'(exp_d));
      chk($sformatf("rnd%0d_irq", i), 32'(Irq), 32'(m_busy));
      chk($sformatf("rnd%0d_hw", i), 32'(HW_INT), 32'(m_hw()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
